// File: rtl/oled_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module : oled_spi_sequencer
// Brief  : SPI byte sequencer for an OLED controller. It sends a ROM init burst,
//          then forwards a handshaked byte stream with a per-byte D/C level.
// Rev    : 1.0  initial release
// ============================================================================

module oled_spi_sequencer #(
   parameter int                  CLK_DIV   = 2,
   parameter int                  N_INIT    = 8,
   parameter logic [8*N_INIT-1:0] INIT_ROM  = 64'hAF_A4_F1_D9_CF_81_14_8D,
   parameter bit                  CPOL      = 1'b0,
   parameter bit                  MSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_dc,
   output logic       tx_ready,
   output logic       sclk,
   output logic       mosi,
   output logic       cs_n,
   output logic       dc,
   output logic       busy,
   output logic       init_done
);

   localparam int              c_HW       = $clog2(CLK_DIV + 1);
   localparam logic [c_HW-1:0] c_HALF_MAX = c_HW'(CLK_DIV - 1);
   localparam logic [6:0]      c_LAST_IDX = 7'(N_INIT - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_INIT = 2'd1, S_STREAM = 2'd2} state_t;
   typedef enum logic [1:0] {P_NONE = 2'd0, P_SHIFT = 2'd1, P_GAP = 2'd2} phase_t;

   state_t          r_state;
   phase_t          r_phase;
   logic [c_HW-1:0] r_hcnt;
   logic [3:0]      r_bcnt;
   logic [6:0]      r_idx;
   logic [7:0]      r_shreg;
   logic            r_sclk, r_mosi, r_cs_n, r_dc, r_busy, r_init_done;

   logic       w_last_half;
   logic [3:0] w_bcnt_nx;
   logic [6:0] w_idx_nx;
   logic [7:0] w_rom_nx;
   logic       w_launch, w_restart, w_dc;
   logic [7:0] w_byte;

   function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] i);
      return MSB_FIRST ? b[3'd7 - i] : b[i];
   endfunction

   assign w_last_half = (r_hcnt == c_HALF_MAX);
   assign w_bcnt_nx   = r_bcnt + 4'd1;
   assign w_idx_nx    = r_idx + 7'd1;

   always_comb begin
      w_rom_nx = 8'h00;
      for (int j = 0; j < N_INIT; j++) begin
         if (w_idx_nx == 7'(j)) w_rom_nx = INIT_ROM[8*j +: 8];
      end
   end

   // One place decides whether a new byte is launched at this edge and what it is.
   always_comb begin
      w_launch  = 1'b0;
      w_restart = 1'b0;
      w_byte    = INIT_ROM[7:0];
      w_dc      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_launch  = 1'b1;
               w_restart = 1'b1;
            end
         end
         S_INIT: begin
            if (r_phase == P_GAP && w_last_half && r_idx != c_LAST_IDX) begin
               w_launch = 1'b1;
               w_byte   = w_rom_nx;
            end
         end
         S_STREAM: begin
            if (r_phase == P_NONE) begin
               if (start) begin
                  w_launch  = 1'b1;
                  w_restart = 1'b1;
               end else if (tx_valid) begin
                  w_launch = 1'b1;
                  w_byte   = tx_data;
                  w_dc     = tx_dc;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_phase     <= P_NONE;
         r_hcnt      <= '0;
         r_bcnt      <= '0;
         r_idx       <= '0;
         r_shreg     <= '0;
         r_sclk      <= CPOL;
         r_mosi      <= 1'b0;
         r_cs_n      <= 1'b1;
         r_dc        <= 1'b0;
         r_busy      <= 1'b0;
         r_init_done <= 1'b0;
      end else if (w_launch) begin
         r_phase <= P_SHIFT;
         r_hcnt  <= '0;
         r_bcnt  <= '0;
         r_shreg <= w_byte;
         r_dc    <= w_dc;
         r_cs_n  <= 1'b0;
         r_sclk  <= CPOL;
         r_mosi  <= pick_bit(w_byte, 3'd0);
         r_busy  <= 1'b1;
         if (w_restart) begin
            r_state     <= S_INIT;
            r_idx       <= '0;
            r_init_done <= 1'b0;
         end else if (r_state == S_INIT) begin
            r_idx <= w_idx_nx;
         end
      end else begin
         case (r_phase)
            P_SHIFT: begin
               if (w_last_half) begin
                  r_hcnt <= '0;
                  if (r_bcnt == 4'd15) begin
                     r_phase <= P_GAP;
                     r_cs_n  <= 1'b1;
                     r_sclk  <= CPOL;
                     r_mosi  <= 1'b0;
                  end else begin
                     r_bcnt <= w_bcnt_nx;
                     r_sclk <= CPOL ^ w_bcnt_nx[0];
                     r_mosi <= pick_bit(r_shreg, w_bcnt_nx[3:1]);
                  end
               end else begin
                  r_hcnt <= r_hcnt + c_HW'(1);
               end
            end
            P_GAP: begin
               // Only the final init byte and stream bytes reach here at gap end.
               if (w_last_half) begin
                  r_hcnt  <= '0;
                  r_bcnt  <= '0;
                  r_phase <= P_NONE;
                  r_busy  <= 1'b0;
                  if (r_state == S_INIT) begin
                     r_state     <= S_STREAM;
                     r_init_done <= 1'b1;
                  end
               end else begin
                  r_hcnt <= r_hcnt + c_HW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign tx_ready  = (r_state == S_STREAM) && (r_phase == P_NONE) && !start;
   assign sclk      = r_sclk;
   assign mosi      = r_mosi;
   assign cs_n      = r_cs_n;
   assign dc        = r_dc;
   assign busy      = r_busy;
   assign init_done = r_init_done;

endmodule

`default_nettype wire
